// File: rtl/uart_tx_fifo_if.sv
// Register-bus bundle between the CPU data-memory port and uart_tx_fifo.
// The CPU side drives select/write/address/data; the device returns read data.
interface uart_tx_fifo_if;
   logic        sel_i;
   logic        we_i;
   logic [1:0]  addr_i;
   logic [31:0] data_i;
   logic [31:0] data_o;

   modport master (
      output sel_i, we_i, addr_i, data_i,
      input  data_o
   );

   modport slave (
      input  sel_i, we_i, addr_i, data_i,
      output data_o
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// Memory-mapped 8N1 UART transmitter fed by a byte FIFO.
// Registers: TXDATA, STATUS, DIV, CTRL; read data is registered.
module uart_tx_fifo #(
   parameter int DIV_RESET = 16,
   parameter int FIFO_AW   = 4
) (
   input  logic           wclk,
   input  logic           rst,
   uart_tx_fifo_if.slave  bus,
   output logic           txd_o,
   output logic           irq_o
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] LVL_ONE  = 1;
   localparam logic [FIFO_AW:0] LVL_FULL =
      (FIFO_AW+1)'(DEPTH);
   localparam logic [FIFO_AW-1:0] PTR_ONE = 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t state_q, state_d;

   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] wptr_q, rptr_q;
   logic [FIFO_AW:0]   level_q;
   logic               ovf_q;
   logic [15:0]        div_q;
   logic               tx_en_q, irq_en_q;
   logic [15:0]        cnt_q, cnt_d;
   logic [2:0]         idx_q, idx_d;
   logic [7:0]         shift_q, shift_d;
   logic               txd_q, irq_q;
   logic [31:0]        data_q, rdata;

   logic wr, rd, push_req, div_wr, ctrl_wr;
   logic flush, ovf_clr, push_ok, ovf_set;
   logic full, empty, busy, pop, can_pop, tick;
   logic [15:0] reload;
   logic unused_ok;

   assign wr       = bus.sel_i & bus.we_i;
   assign rd       = bus.sel_i & ~bus.we_i;
   assign push_req = wr & (bus.addr_i == 2'd0);
   assign div_wr   = wr & (bus.addr_i == 2'd2);
   assign ctrl_wr  = wr & (bus.addr_i == 2'd3);
   assign flush    = ctrl_wr & bus.data_i[2];
   assign ovf_clr  = ctrl_wr & bus.data_i[3];

   assign full  = (level_q == LVL_FULL);
   assign empty = (level_q == '0);
   assign busy  = (state_q != S_IDLE);

   // Flush discards a concurrent push without flagging overflow.
   assign push_ok = push_req & ~flush & (~full | pop);
   assign ovf_set = push_req & ~flush & full & ~pop;

   assign can_pop = tx_en_q & ~empty;
   assign tick    = (cnt_q == 16'd0);
   assign reload  = div_q - 16'd1;

   assign unused_ok = ^bus.data_i[31:16];

   always_ff @(posedge wclk) begin
      if (push_ok) mem[wptr_q] <= bus.data_i[7:0];
   end

   always_ff @(posedge wclk or negedge rst) begin
      if (!rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else if (flush) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         if (push_ok) wptr_q <= wptr_q + PTR_ONE;
         if (pop)     rptr_q <= rptr_q + PTR_ONE;
         if (push_ok & ~pop)
            level_q <= level_q + LVL_ONE;
         else if (pop & ~push_ok)
            level_q <= level_q - LVL_ONE;
      end
   end

   always_ff @(posedge wclk or negedge rst) begin
      if (!rst) begin
         ovf_q    <= 1'b0;
         div_q    <= 16'(DIV_RESET);
         tx_en_q  <= 1'b1;
         irq_en_q <= 1'b0;
      end else begin
         if (ovf_clr)      ovf_q <= 1'b0;
         else if (ovf_set) ovf_q <= 1'b1;
         if (div_wr)
            div_q <= (bus.data_i[15:0] == 16'd0) ?
                     16'd1 : bus.data_i[15:0];
         if (ctrl_wr) begin
            tx_en_q  <= bus.data_i[0];
            irq_en_q <= bus.data_i[1];
         end
      end
   end

   always_ff @(posedge wclk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
      end
   end

   // The bit counter reloads from div_q at each period boundary,
   // so a DIV write only affects the next bit period.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      pop     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (can_pop) begin
               pop     = 1'b1;
               shift_d = mem[rptr_q];
               cnt_d   = reload;
               state_d = S_START;
            end
         end
         S_START: begin
            if (tick) begin
               cnt_d   = reload;
               idx_d   = 3'd0;
               state_d = S_DATA;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         S_DATA: begin
            if (tick) begin
               cnt_d   = reload;
               shift_d = shift_q >> 1;
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) state_d = S_STOP;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         S_STOP: begin
            if (tick) begin
               if (can_pop) begin
                  pop     = 1'b1;
                  shift_d = mem[rptr_q];
                  cnt_d   = reload;
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
      endcase
   end

   always_ff @(posedge wclk or negedge rst) begin
      if (!rst) begin
         txd_q <= 1'b1;
         irq_q <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE:  txd_q <= 1'b1;
            S_START: txd_q <= 1'b0;
            S_DATA:  txd_q <= shift_q[0];
            S_STOP:  txd_q <= 1'b1;
         endcase
         irq_q <= irq_en_q & empty & ~busy;
      end
   end

   always_comb begin
      rdata = '0;
      unique case (bus.addr_i)
         2'd0: rdata = '0;
         2'd1: begin
            rdata[0] = full;
            rdata[1] = empty;
            rdata[2] = busy;
            rdata[3] = ovf_q;
            rdata[8 +: FIFO_AW+1] = level_q;
         end
         2'd2: rdata[15:0] = div_q;
         2'd3: begin
            rdata[0] = tx_en_q;
            rdata[1] = irq_en_q;
         end
      endcase
   end

   always_ff @(posedge wclk or negedge rst) begin
      if (!rst)    data_q <= '0;
      else if (rd) data_q <= rdata;
   end

   assign bus.data_o = data_q;
   assign txd_o      = txd_q;
   assign irq_o      = irq_q;

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Memory-mapped UART transmitter with a byte FIFO. Sits downstream of the CPU data-memory port, in parallel with memory and simple_uart; consumes CPU stores and serialises them onto txd_o as 8N1 frames.
- Exposes status, divisor and control registers. Read data is registered so the top level muxes it into dm_data_l one cycle after select.

Parameters:
- DIV_RESET, 16: reset value of the baud divisor, in wclk cycles per bit.
- FIFO_AW, 4: FIFO address width; depth = 2**FIFO_AW = 16 bytes.

Ports:
- wclk   input   1   clock
- rst    input   1   reset, asynchronous, active-low
- sel_i  input   1   block selected for this cycle's access (load or store)
- we_i   input   1   1 = write access, 0 = read access; qualified by sel_i
- addr_i input   2   register index (word address bits [3:2])
- data_i input   32  write data
- data_o output  32  registered read data
- txd_o  output  1   serial output, idle high
- irq_o  output  1   level interrupt: FIFO empty and transmitter idle, while IRQ enable is set

Behaviour:
- Register map (addr_i):
  - 0 TXDATA, write: push data_i[7:0]. Reads return 0.
  - 1 STATUS, read-only:
    - bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky)
    - bits[8+FIFO_AW:8] level, 0..depth
  - 2 DIV, R/W bits[15:0]. A written value of 0 is stored as 1.
  - 3 CTRL, R/W:
    - bit0 tx_en
    - bit1 irq_en
    - bit2 write-1 flush, self-clearing, reads 0
    - bit3 write-1 clears overflow, reads 0
- Reset state:
  - txd_o=1, data_o=0, irq_o=0
  - FIFO empty, level=0, overflow=0
  - DIV=DIV_RESET, tx_en=1, irq_en=0, FSM=IDLE
- Reads: when sel_i=1 and we_i=0, data_o gets the register value at the next wclk edge (1-cycle latency). data_o holds its value otherwise.
- Writes take effect on the wclk edge where sel_i=1 and we_i=1.
- FIFO:
  - Circular buffer with FIFO_AW-bit read and write pointers that wrap; separate level counter, width FIFO_AW+1.
  - Push accepted when level<depth, or when a pop occurs in the same cycle.
  - A push rejected while full drops the byte and sets overflow; level and contents are unchanged.
  - Simultaneous push and pop: level unchanged, both pointers advance.
- Flush: resets both pointers and level to 0 in one cycle. It does not abort the frame in progress. A push in the same cycle as a flush is discarded (flush wins; overflow is not set).
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - Each state holds for DIV cycles, timed by a 16-bit bit counter.
  - IDLE: txd_o=1. If tx_en=1 and level>0, pop the head byte into the shift register and go to START. The pop happens on that edge.
  - START: txd_o=0.
  - DATA: txd_o=shift[0]. Shift right after each bit period; 8 bits, LSB first, tracked by a 3-bit bit index.
  - STOP: txd_o=1 for DIV cycles, then IDLE. Back-to-back frames: the next START begins the cycle after STOP ends if the FIFO is non-empty.
  - Frame length is exactly 10*DIV cycles.
- Writing DIV mid-frame: the new value applies from the next bit period. The current period completes using its loaded count.
- tx_en cleared mid-frame: the current frame completes; no further pops.
- Asynchronous reset mid-frame: txd_o goes to 1 immediately and all state returns to reset values.
- irq_o = irq_en & empty & IDLE; registered, so it updates one cycle after its conditions change.
- txd_o is driven from a flop (glitch-free).

Test Plan:
- Reset, then DIV=4, write 0x55 to TXDATA -> txd_o low at the edge after the push edge plus 1 cycle. Bits 1,0,1,0,1,0,1,0, then stop high, each 4 cycles; total 40 cycles. STATUS busy=1 during the frame, empty=1 after the pop.
- Push 17 bytes 0x00..0x10 with tx_en=0 -> STATUS level=16, full=1, overflow=1. Byte 0x10 is dropped. Set tx_en=1: 16 back-to-back frames 0x00..0x0F with no idle gap between STOP and START.
- FIFO full, tx_en=1: a push in the same cycle as the IDLE->START pop -> push accepted, level stays 16, overflow stays 0.
- Three bytes queued, frame 1 in progress, write CTRL=0x5 (flush) -> frame 1 completes, then txd_o stays 1. STATUS reads level=0, empty=1. CTRL readback=0x1.
- irq_en=1, push one byte with DIV=2 -> irq_o=0 during the 20-cycle frame and returns to 1 one cycle after STOP ends. Write DIV=0 -> DIV reads back 1.
- Assert rst low mid-DATA -> txd_o=1, data_o=0, DIV=16 immediately. After release, STATUS reads 0x00000002 (empty only).
